logic_gate_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit and the successor to the single two-input gate primitives in the gates library. Each accepted transaction applies one of eight selectable gate operations bitwise across WIDTH-bit operands. It also supports a NAND-accumulate mode that folds operands into an internal register. Transactions move through a two-stage elastic pipeline with valid/ready handshakes on both sides, so the block sits between any producer and consumer that can stall.

---
 rtl/logic_gate_pipe.sv | 124 ++++++++++++
 tb/tb_logic_gate_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - two-stage elastic bitwise logic unit with NAND-accumulate
//
// Purpose: applies one of eight bitwise gate operations to WIDTH-bit operands.
// Op 7 folds the operand into an internal accumulator. Transactions flow through
// two register stages with valid/ready handshakes on input and output.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake
//   a, b, op              operands and operation select (captured together)
//   acc_clr               clear accumulator to all-ones (synchronous)
//   out_valid/out_ready   output handshake
//   y, zero               result and (y == 0) flag, both registered
module logic_gate_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero
);
    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_NACC = 3'd7;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic [WIDTH-1:0] r_acc;

    logic             w_s2_adv;
    logic             w_s1_move;
    logic             w_in_fire;
    logic             w_acc_load;
    logic [WIDTH-1:0] w_acc_eff;
    logic [WIDTH-1:0] w_result;

    // Stage 2 frees up whenever it is empty or its result is being taken,
    // which gives the pass-through ready path from out_ready to in_ready.
    assign w_s2_adv   = !r_s2_valid || out_ready;
    assign w_s1_move  = r_s1_valid && w_s2_adv;
    assign in_ready   = !r_s1_valid || w_s2_adv;
    assign w_in_fire  = in_valid && in_ready;
    assign w_acc_load = w_s1_move && (r_s1_op == OP_NACC);

    // A clear in the same cycle as an op-7 entry is applied before the fold.
    assign w_acc_eff  = acc_clr ? {WIDTH{1'b1}} : r_acc;

    always_comb begin
        w_result = '0;
        case (r_s1_op)
            OP_NAND: w_result = ~(r_s1_a & r_s1_b);
            OP_AND:  w_result = r_s1_a & r_s1_b;
            OP_OR:   w_result = r_s1_a | r_s1_b;
            OP_NOR:  w_result = ~(r_s1_a | r_s1_b);
            OP_XOR:  w_result = r_s1_a ^ r_s1_b;
            OP_XNOR: w_result = ~(r_s1_a ^ r_s1_b);
            OP_NOT:  w_result = ~r_s1_a;
            default: w_result = ~(w_acc_eff & r_s1_a);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OP_NAND;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_in_fire) begin
                r_s1_a  <= a;
                r_s1_b  <= b;
                r_s1_op <= op;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_zero     <= 1'b1;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y    <= w_result;
                r_zero <= (w_result == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= {WIDTH{1'b1}};
        end else if (w_acc_load) begin
            r_acc <= w_result;
        end else if (acc_clr) begin
            r_acc <= {WIDTH{1'b1}};
        end
    end

    assign out_valid = r_s2_valid;
    assign y         = r_y;
    assign zero      = r_zero;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb/tb_logic_gate_pipe.sv - self-checking bench for logic_gate_pipe (WIDTH 8, 32, 1)
module tb_logic_gate_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a_bus;
    logic [31:0] b_bus;
    logic [2:0]  op;
    logic        acc_clr;
    logic        out_ready;

    logic        in_ready8, out_valid8, zero8;
    logic [7:0]  y8;
    logic        in_ready32, out_valid32, zero32;
    logic [31:0] y32;
    logic        in_ready1, out_valid1, zero1;
    logic [0:0]  y1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .op(op), .acc_clr(acc_clr),
        .out_valid(out_valid8), .out_ready(out_ready), .y(y8), .zero(zero8)
    );

    logic_gate_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .a(a_bus), .b(b_bus), .op(op), .acc_clr(acc_clr),
        .out_valid(out_valid32), .out_ready(out_ready), .y(y32), .zero(zero32)
    );

    logic_gate_pipe #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a_bus[0:0]), .b(b_bus[0:0]), .op(op), .acc_clr(acc_clr),
        .out_valid(out_valid1), .out_ready(out_ready), .y(y1), .zero(zero1)
    );

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        logic [7:0] y;
        logic       z;
    } vec_t;

    vec_t        tv [16];
    logic [31:0] expq [$];
    logic [31:0] m_acc;
    logic [31:0] e;
    logic [31:0] r;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction on an idle pipeline; checks the two-edge latency.
    task automatic run_one(input string name, input logic [2:0] o, input logic [31:0] av,
                           input logic [31:0] bv, input logic [7:0] ey);
        in_valid = 1'b1; op = o; a_bus = av; b_bus = bv; out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_in_ready"}, in_ready8, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_early_valid"}, out_valid8, 0);
        tick();
        @(negedge clk);
        chk({name, "_valid"}, out_valid8, 1);
        chk({name, "_y"}, y8, ey);
        tick();
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] w, input logic [31:0] acc);
        case (o)
            3'd0:    return ~(x & w);
            3'd1:    return x & w;
            3'd2:    return x | w;
            3'd3:    return ~(x | w);
            3'd4:    return x ^ w;
            3'd5:    return ~(x ^ w);
            3'd6:    return ~x;
            default: return ~(acc & x);
        endcase
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a_bus = '0; b_bus = '0; op = '0;
        acc_clr = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready8, 1);
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_y", y8, 0);
        chk("rst_zero", zero8, 1);
        chk("rst_y32", y32, 0);
        chk("rst_zero1", zero1, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready8, 1);
        chk("post_rst_out_valid", out_valid8, 0);
        tick();

        // Back-to-back table: op, a, b, clear-at-stage-2-entry, y, zero
        tv[0]  = {3'd0, 8'hF0, 8'h3C, 1'b0, 8'hCF, 1'b0};
        tv[1]  = {3'd4, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0};
        tv[2]  = {3'd0, 8'hA5, 8'h0F, 1'b0, 8'hFA, 1'b0};
        tv[3]  = {3'd1, 8'hA5, 8'h0F, 1'b0, 8'h05, 1'b0};
        tv[4]  = {3'd2, 8'hA5, 8'h0F, 1'b0, 8'hAF, 1'b0};
        tv[5]  = {3'd3, 8'hA5, 8'h0F, 1'b0, 8'h50, 1'b0};
        tv[6]  = {3'd4, 8'hA5, 8'h0F, 1'b0, 8'hAA, 1'b0};
        tv[7]  = {3'd5, 8'hA5, 8'h0F, 1'b0, 8'h55, 1'b0};
        tv[8]  = {3'd6, 8'hA5, 8'h0F, 1'b0, 8'h5A, 1'b0};
        tv[9]  = {3'd1, 8'hAA, 8'h55, 1'b0, 8'h00, 1'b1};
        tv[10] = {3'd7, 8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0};
        tv[11] = {3'd7, 8'hFF, 8'h00, 1'b0, 8'h0F, 1'b0};
        tv[12] = {3'd0, 8'h12, 8'h34, 1'b0, 8'hEF, 1'b0};
        tv[13] = {3'd7, 8'hFF, 8'h00, 1'b0, 8'hF0, 1'b0};
        tv[14] = {3'd7, 8'h33, 8'h00, 1'b1, 8'hCC, 1'b0};
        tv[15] = {3'd7, 8'hCC, 8'h00, 1'b0, 8'h33, 1'b0};

        out_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin
                in_valid = 1'b1; op = tv[c].op;
                a_bus = {24'h0, tv[c].a}; b_bus = {24'h0, tv[c].b};
            end else begin
                in_valid = 1'b0;
            end
            acc_clr = (c >= 1 && c <= 16) ? tv[c-1].clr : 1'b0;
            @(negedge clk);
            if (c < 16) chk($sformatf("tbl%0d_in_ready", c), in_ready8, 1);
            if (c >= 2) begin
                chk($sformatf("tbl%0d_valid", c-2), out_valid8, 1);
                chk($sformatf("tbl%0d_y", c-2), y8, tv[c-2].y);
                chk($sformatf("tbl%0d_zero", c-2), zero8, tv[c-2].z);
            end
            tick();
        end
        acc_clr = 1'b0;
        @(negedge clk);
        chk("tbl_drained", out_valid8, 0);
        tick();

        // Backpressure: three offered, two accepted, third held
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd1; a_bus = 32'hFF; b_bus = 32'h0F;
        @(negedge clk);
        chk("bp_acc0", in_ready8, 1);
        tick();
        op = 3'd2; a_bus = 32'hF0; b_bus = 32'h0F;
        @(negedge clk);
        chk("bp_acc1", in_ready8, 1);
        chk("bp_not_yet", out_valid8, 0);
        tick();
        op = 3'd4; a_bus = 32'hFF; b_bus = 32'h0F;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_full_ready%0d", k), in_ready8, 0);
            chk($sformatf("bp_hold_valid%0d", k), out_valid8, 1);
            chk($sformatf("bp_hold_y%0d", k), y8, 8'h0F);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pass_ready", in_ready8, 1);
        chk("bp_out0", y8, 8'h0F);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out1_valid", out_valid8, 1);
        chk("bp_out1", y8, 8'hFF);
        tick();
        @(negedge clk);
        chk("bp_out2_valid", out_valid8, 1);
        chk("bp_out2", y8, 8'hF0);
        tick();
        @(negedge clk);
        chk("bp_empty", out_valid8, 0);

        // Build acc = 0xF0: clear while idle, then op 7 with a = 0x0F
        in_valid = 1'b1; op = 3'd7; a_bus = 32'h0F; acc_clr = 1'b1;
        tick();
        in_valid = 1'b0; acc_clr = 1'b0;
        tick();
        @(negedge clk);
        chk("acc_build_y", y8, 8'hF0);
        tick();

        // Two items in flight, then asynchronous reset
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd0; a_bus = 32'h11; b_bus = 32'h22;
        tick();
        op = 3'd2;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_inflight", out_valid8, 1);
        chk("mid_full", in_ready8, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid8, 0);
        chk("mid_rst_y", y8, 0);
        chk("mid_rst_zero", zero8, 1);
        chk("mid_rst_ready", in_ready8, 1);
        tick();
        rst = 1'b0;
        run_one("post_rst_nacc", 3'd7, 32'h0F, 32'h0, 8'hF0);
        @(negedge clk);
        chk("post_rst_no_ghost", out_valid8, 0);
        tick();

        // Random run across WIDTH 8/32/1 against a transaction-level model
        begin
            int  sent;
            int  got;
            int  cyc;
            bit  hold;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            m_acc = '1;
            expq.delete();
            sent = 0; got = 0; cyc = 0; hold = 1'b0;
            in_valid = 1'b0;
            while (got < 1000 && cyc < 20000) begin
                if (!hold) begin
                    if (sent < 1000 && $urandom_range(0, 9) < 7) begin
                        in_valid = 1'b1;
                        op = 3'($urandom_range(0, 7));
                        a_bus = $urandom;
                        b_bus = $urandom;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                out_ready = ($urandom_range(0, 9) < 7);
                // Clear only with nothing outstanding, so no op 7 can be entering stage 2.
                acc_clr = (sent == got) && ($urandom_range(0, 9) == 0);
                @(negedge clk);
                if (acc_clr) m_acc = '1;
                if (out_valid8 && out_ready) begin
                    if (expq.size() == 0) begin
                        chk("rnd_extra_output", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("rnd_valid32", out_valid32, 1);
                        chk("rnd_valid1", out_valid1, 1);
                        chk("rnd_y8", y8, e[7:0]);
                        chk("rnd_y32", y32, e);
                        chk("rnd_y1", y1, e[0]);
                        chk("rnd_zero8", zero8, e[7:0] == 8'h0);
                        chk("rnd_zero32", zero32, e == 32'h0);
                        chk("rnd_zero1", zero1, !e[0]);
                    end
                    got++;
                end
                if (in_valid && in_ready8) begin
                    chk("rnd_in_ready32", in_ready32, 1);
                    chk("rnd_in_ready1", in_ready1, 1);
                    r = ref_op(op, a_bus, b_bus, m_acc);
                    if (op == 3'd7) m_acc = r;
                    expq.push_back(r);
                    sent++;
                    hold = 1'b0;
                end else begin
                    hold = in_valid;
                end
                cyc++;
                tick();
            end
            in_valid = 1'b0; acc_clr = 1'b0;
            chk("rnd_sent", sent, 1000);
            chk("rnd_received", got, 1000);
            chk("rnd_leftover", expq.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
